// File: rtl/iir_axil_regs_pkg.sv
// Shared constants and types for the IIR AXI4-Lite register block.
// Contents:
//   AXI_RESP_OKAY    - the only response code the block issues
//   REG_IDX_W        - width of a register index (ADDR[3:2])
//   NUM_REGS         - number of 32-bit registers
//   REG_CTRL..REG_3  - register index constants (REG_CTRL feeds the core's control input)
//   reg_word_t       - one 32-bit register word
//   reg_idx_t        - register index
package iir_axil_pkg;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam int unsigned REG_IDX_W     = 2;
  localparam int unsigned NUM_REGS      = 4;

  typedef logic [31:0]          reg_word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_CTRL = 2'd0;
  localparam reg_idx_t REG_1    = 2'd1;
  localparam reg_idx_t REG_2    = 2'd2;
  localparam reg_idx_t REG_3    = 2'd3;

endpackage

// File: rtl/iir_axil_regs_if.sv
// AXI4-Lite bus bundle between the AXI master (VIP / interconnect) and the
// IIR register block.
// Parameters: ADDR_W (byte-address width), DATA_W (data width).
// Signal groups:
//   AW: awaddr, awprot, awvalid, awready
//   W : wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready
//   AR: araddr, arprot, arvalid, arready
//   R : rdata, rresp, rvalid, rready
// Modports: master (drives requests), slave (drives ready/response).
interface iir_axil_regs_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/iir_axil_regs.sv
// AXI4-Lite responder for the IIR IP's S00_AXI port: four 32-bit R/W
// registers driven straight to the IIR core.
// Ports:
//   S_AXI_ACLK     - clock
//   S_AXI_ARESETN  - asynchronous active-low reset
//   s_axi          - AXI4-Lite slave bundle (AW/W/B/AR/R)
//   reg_q          - register contents to the core (reg_q[REG_CTRL] = control)
//   reg_wr_pulse   - one-cycle strobe per register, the cycle after it is written
// AW and W each have a one-entry holding buffer so they may arrive in any
// order; a write commits once both are available and the B slot is free.
// Reads use a single output stage. Every response is OKAY.
module iir_axil_regs
  import iir_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_NUM_REGS         = NUM_REGS
) (
  input  logic                                          S_AXI_ACLK,
  input  logic                                          S_AXI_ARESETN,
  iir_axil_regs_if.slave                                s_axi,
  output logic [C_NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [C_NUM_REGS-1:0]                         reg_wr_pulse
);

  localparam int unsigned NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  // Write-path holding buffers
  logic                          aw_full;
  reg_idx_t                      aw_idx_q;
  logic                          w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [NUM_BYTES-1:0]          w_strb_q;
  logic                          bvalid_q;

  // Read output stage
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          fire;
  reg_idx_t                      wr_idx;
  reg_idx_t                      rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]          wr_strb;

  // PROT and the byte-offset address bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         s_axi.awprot, s_axi.arprot};

  assign s_axi.awready = ~aw_full;
  assign s_axi.wready  = ~w_full;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.arready = ~rvalid_q | s_axi.rready;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = AXI_RESP_OKAY;

  assign aw_hs = s_axi.awvalid & ~aw_full;
  assign w_hs  = s_axi.wvalid  & ~w_full;
  assign ar_hs = s_axi.arvalid & s_axi.arready;

  // READY is low whenever a buffer is full, so at most one source per
  // channel is live: the buffer if full, otherwise the bus.
  assign wr_idx  = aw_full ? aw_idx_q : reg_idx_t'(s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign wr_data = w_full  ? w_data_q : s_axi.wdata;
  assign wr_strb = w_full  ? w_strb_q : s_axi.wstrb;
  assign rd_idx  = reg_idx_t'(s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]);

  assign fire = (aw_full | aw_hs) & (w_full | w_hs) & (~bvalid_q | s_axi.bready);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full      <= 1'b0;
      aw_idx_q     <= '0;
      w_full       <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      reg_q        <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;

      if (fire) begin
        // Consumes whatever was buffered or handshaking; a B handshake on
        // this edge is absorbed by re-asserting BVALID for the new write.
        aw_full              <= 1'b0;
        w_full               <= 1'b0;
        bvalid_q             <= 1'b1;
        reg_wr_pulse[wr_idx] <= 1'b1;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
          if (wr_strb[b]) begin
            reg_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end else begin
        if (aw_hs) begin
          aw_full  <= 1'b1;
          aw_idx_q <= reg_idx_t'(s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
        if (s_axi.bready) begin
          bvalid_q <= 1'b0;
        end
      end

      // reg_q here is the pre-write value, so a same-edge write is not seen.
      if (ar_hs) begin
        rdata_q  <= reg_q[rd_idx];
        rvalid_q <= 1'b1;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iir_axil_regs.sv
// Self-checking bench for iir_axil_regs: directed scenarios (reset, basic
// write/read, skewed AW/W, B back-pressure, R back-pressure with a
// same-edge write, reset mid-transaction) followed by randomized traffic,
// all checked against a register-array model of the block.
module tb_iir_axil_regs;
  import iir_axil_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_REGS-1:0][31:0] reg_q;
  logic [NUM_REGS-1:0]       pulse;

  iir_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  iir_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus),
    .reg_q        (reg_q),
    .reg_wr_pulse (pulse)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  reg_word_t   model [NUM_REGS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-enable merge expressed as a mask.
  function automatic reg_word_t merge(input reg_word_t old, input reg_word_t data,
                                      input logic [3:0] strb);
    reg_word_t mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), reg_q[i], model[i]);
    end
  endtask

  // Write with AW/W asserted aw_dly/w_dly cycles after the start; BREADY=1.
  task automatic axi_write(input logic [3:0] addr, input reg_word_t data,
                           input logic [3:0] strb, input int unsigned aw_dly,
                           input int unsigned w_dly);
    int unsigned cyc;
    bit aw_done, w_done, aw_now, w_now;
    logic [1:0] idx;
    cyc = 0; aw_done = 0; w_done = 0;
    idx = addr[3:2];
    @(negedge clk);
    bus.bready = 1'b1;
    bus.awaddr = addr;
    bus.awprot = 3'($urandom);
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done  && (cyc >= w_dly);
      #1;
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid  && bus.wready;
      @(posedge clk);
      aw_done |= aw_now;
      w_done  |= w_now;
      @(negedge clk);
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wr_accept", {30'b0, aw_done, w_done}, 32'h3);
    model[idx] = merge(model[idx], data, strb);
    check("wr_bvalid", bus.bvalid, 1'b1);
    check("wr_bresp", bus.bresp, AXI_RESP_OKAY);
    check("wr_pulse", pulse, 32'(1) << idx);
    check("wr_reg", reg_q[idx], model[idx]);
    @(posedge clk); #1;
    check("wr_bclear", bus.bvalid, 1'b0);
    check("wr_pulse_clear", pulse, 0);
  endtask

  // Read, then hold RREADY low for 'stall' cycles.
  task automatic axi_read(input logic [3:0] addr, input int unsigned stall);
    int unsigned cyc;
    bit hs;
    reg_word_t exp;
    cyc = 0; hs = 0;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom);
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    while (!hs && cyc < 40) begin
      #1;
      hs = bus.arvalid && bus.arready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.arvalid = 1'b0;
    check("rd_accept", 32'(hs), 1);
    exp = model[addr[3:2]];
    check("rd_rvalid", bus.rvalid, 1'b1);
    check("rd_rresp", bus.rresp, AXI_RESP_OKAY);
    check("rd_rdata", bus.rdata, exp);
    if (stall > 0) begin
      bus.rready = 1'b0;
      for (int unsigned i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("rd_stall_rdata", bus.rdata, exp);
        check("rd_stall_arready", bus.arready, 1'b0);
      end
      @(negedge clk);
      bus.rready = 1'b1;
    end
    @(posedge clk); #1;
    check("rd_rclear", bus.rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_word_t old;
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_awready", bus.awready, 1'b1);
    check("rst_wready", bus.wready, 1'b1);
    check("rst_arready", bus.arready, 1'b1);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_pulse", pulse, 0);
    check_all_regs("rst");

    // 2: write 1..4, read back
    for (int i = 0; i < NUM_REGS; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) axi_read(4'(i * 4), 0);
    check("t2_reg3", reg_q[REG_3], 32'h4);

    // 3: W first, AW three cycles later, partial strobe
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0011, 3, 0);
    check("t3_reg1", reg_q[REG_1], 32'h0000_CCDD);

    // 4: BREADY low across three writes
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awaddr = 4'h4; bus.wdata = 32'h1111_0001; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    model[REG_1] = 32'h1111_0001;
    check("t4_b1_valid", bus.bvalid, 1'b1);
    check("t4_b1_pulse", pulse, 4'b0010);
    @(negedge clk);
    bus.awaddr = 4'hC; bus.wdata = 32'h3333_0002;
    @(posedge clk); #1;
    check("t4_awready_low", bus.awready, 1'b0);
    check("t4_wready_low", bus.wready, 1'b0);
    check("t4_b2_held", pulse, 0);
    check("t4_reg3_held", reg_q[REG_3], model[REG_3]);
    @(negedge clk);
    bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'b0101;
    repeat (3) begin
      @(posedge clk); #1;
      check("t4_stall_awready", bus.awready, 1'b0);
      check("t4_stall_bvalid", bus.bvalid, 1'b1);
    end
    @(negedge clk);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    model[REG_3] = 32'h3333_0002;
    check("t4_b2_valid", bus.bvalid, 1'b1);
    check("t4_b2_pulse", pulse, 4'b1000);
    check("t4_b2_reg3", reg_q[REG_3], model[REG_3]);
    @(posedge clk); #1;
    model[REG_3] = merge(model[REG_3], 32'h5555_AAAA, 4'b0101);
    check("t4_b3_valid", bus.bvalid, 1'b1);
    check("t4_b3_pulse", pulse, 4'b1000);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge clk); #1;
    check("t4_bclear", bus.bvalid, 1'b0);
    check("t4_reg3_final", reg_q[REG_3], 32'h3355_00AA);
    check_all_regs("t4");

    // 5: read reg2 with RREADY low; same-edge write to reg2
    @(negedge clk);
    bus.araddr = 4'h8; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.awaddr = 4'h8; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1;
    old = model[REG_2];
    model[REG_2] = 32'hDEAD_BEEF;
    check("t5_rvalid", bus.rvalid, 1'b1);
    check("t5_rdata_old", bus.rdata, old);
    check("t5_reg2_new", reg_q[REG_2], model[REG_2]);
    check("t5_pulse", pulse, 4'b0100);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 4'h0;  // next read waits behind the stalled one
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_stall_rdata", bus.rdata, old);
      check("t5_stall_rvalid", bus.rvalid, 1'b1);
      check("t5_stall_arready", bus.arready, 1'b0);
    end
    @(negedge clk);
    bus.rready = 1'b1;
    #1;
    check("t5_arready_rel", bus.arready, 1'b1);
    @(posedge clk); #1;
    check("t5_next_rvalid", bus.rvalid, 1'b1);
    check("t5_next_rdata", bus.rdata, model[REG_CTRL]);
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    check("t5_rclear", bus.rvalid, 1'b0);

    // 6: reset during a pending B with an AW sitting in its buffer
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awaddr = 4'h0; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    check("t6_bvalid_pending", bus.bvalid, 1'b1);
    @(negedge clk);
    bus.awaddr = 4'h4; bus.wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    #1;
    check("t6_bvalid_rst", bus.bvalid, 1'b0);
    check("t6_awready_rst", bus.awready, 1'b1);
    check_all_regs("t6_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.bready = 1'b1;
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("t6_wready_buffered", bus.wready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_no_bvalid", bus.bvalid, 1'b0);
      check("t6_no_pulse", pulse, 0);
      check("t6_reg1_zero", reg_q[REG_1], 0);
    end
    @(negedge clk);
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    model[REG_1] = 32'hCAFE_F00D;
    check("t6_late_bvalid", bus.bvalid, 1'b1);
    check("t6_late_pulse", pulse, 4'b0010);
    @(negedge clk);
    bus.awvalid = 1'b0;
    @(posedge clk); #1;
    check("t6_late_bclear", bus.bvalid, 1'b0);
    check_all_regs("t6");

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
      if (i % 25 == 24) check_all_regs("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
